// File: rtl/wrr_pkg.sv
// wrr_pkg: shared defaults, FSM states and reset weight for the weighted round-robin scheduler
package wrr_pkg;
  localparam int WRR_N = 8;
  localparam int WRR_WW = 4;
  localparam int WRR_RST_WEIGHT = 1;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority find-first, searching upward from ptr+1 and wrapping round to ptr itself
module rr_pick #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);
  // walk from farthest to nearest so the nearest set bit is assigned last; i==N wraps to ptr
  always_comb begin
    index = ptr;
    for (int i = N; i >= 1; i--)
      if (req[ptr + IW'(i)]) index = ptr + IW'(i);
  end
  assign any = |req;
  assign onehot = any ? N'(1) << index : '0;
endmodule

// File: rtl/weighted_rr_scheduler.sv
// weighted_rr_scheduler: weighted round-robin grant of one shared resource, one transaction per grant
// Define WRR_WEIGHT_EN to build the programmable weight table; otherwise every weight is 1.
module weighted_rr_scheduler
  import wrr_pkg::*;
#(
  parameter int N = WRR_N,
  parameter int WW = WRR_WW,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic [N-1:0]  req,
  input  logic          done,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [WW-1:0] cfg_weight,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          busy
);
  state_t state;
  logic [IW-1:0] ptr;
  logic [WW-1:0] credit;
  logic [N-1:0] pick_oh;
  logic [IW-1:0] pick_idx;
  logic pick_any;
  logic stay;
  logic [N-1:0] win_oh;
  logic [IW-1:0] win_idx;
  logic [WW-1:0] load_w;
  rr_pick #(.N(N)) u_pick (
    .req(req),
    .ptr(ptr),
    .onehot(pick_oh),
    .index(pick_idx),
    .any(pick_any)
  );
  // credit holds the remaining quota of the requester at ptr only
  assign stay = req[ptr] && credit != '0;
  assign win_idx = stay ? ptr : pick_idx;
  assign win_oh = stay ? N'(1) << ptr : pick_oh;
`ifdef WRR_WEIGHT_EN
  logic [WW-1:0] weight [N];
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) weight <= '{default: WW'(WRR_RST_WEIGHT)};
    else if (cfg_we) weight[cfg_idx] <= cfg_weight;
  assign load_w = weight[win_idx] == '0 ? WW'(1) : weight[win_idx];
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_idx, cfg_weight};
  assign load_w = WW'(1);
`endif
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      ptr <= IW'(N - 1);
      credit <= '0;
    end else if (state == IDLE) begin
      if (pick_any) begin
        state <= BUSY;
        grant <= win_oh;
        grant_id <= win_idx;
        ptr <= win_idx;
        credit <= stay ? credit : load_w;
      end
    end else if (done) begin
      state <= IDLE;
      grant <= '0;
      credit <= credit == '0 ? credit : credit - 1'b1;
    end
  assign busy = state == BUSY;
endmodule

// File: tb/tb_weighted_rr_scheduler.sv
// tb_weighted_rr_scheduler: scoreboard bench, reference model of the weighted round-robin rules
module tb_weighted_rr_scheduler;
  localparam int N = 8;
  localparam int WW = 4;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [N-1:0] req = '0;
  logic done = 1'b0;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [WW-1:0] cfg_weight = '0;
  logic [N-1:0] grant;
  logic [2:0] grant_id;
  logic busy;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  bit m_busy;
  int m_ptr;
  int m_credit[N];
  int m_weight[N];

  weighted_rr_scheduler #(.N(N), .WW(WW)) dut (
    .clk(clk),
    .rstN(rstN),
    .req(req),
    .done(done),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_weight(cfg_weight),
    .grant(grant),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0;
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) begin
      m_credit[i] = 0;
      m_weight[i] = 1;
    end
  endfunction

  // stay on ptr while it still has quota, else nearest requester going upward from ptr+1
  function automatic int pick(input logic [N-1:0] r);
    if (r[m_ptr] && m_credit[m_ptr] > 0) return m_ptr;
    for (int k = 1; k <= N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // what the coming rising edge does with the inputs just driven
  function automatic void model_edge();
    int w;
    if (m_busy) begin
      if (done) begin
        m_busy = 0;
        if (m_credit[m_ptr] > 0) m_credit[m_ptr]--;
      end
    end else if (req != '0) begin
      w = pick(req);
      if (w != m_ptr || m_credit[w] == 0) m_credit[w] = m_weight[w] == 0 ? 1 : m_weight[w];
      m_ptr = w;
      m_busy = 1;
      exp_q.push_back(w);
    end
`ifdef WRR_WEIGHT_EN
    if (cfg_we) m_weight[cfg_idx] = cfg_weight;
`endif
  endfunction

  task automatic step(input logic [N-1:0] r, input logic d, input logic we,
                      input logic [2:0] idx, input logic [WW-1:0] w);
    @(negedge clk);
    req = r;
    done = d;
    cfg_we = we;
    cfg_idx = idx;
    cfg_weight = w;
    model_edge();
  endtask

  task automatic run(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, m_busy, 1'b0, 3'd0, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    done = 1'b0;
    cfg_we = 1'b0;
    rstN = 1'b0;
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_grant_id", 32'(grant_id), 32'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // monitor: pops the expected winner on each new grant and checks grant stability and idle gaps
  initial begin
    logic prev_busy;
    logic [N-1:0] held;
    logic [N-1:0] oh;
    int e;
    prev_busy = 1'b0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (busy && !prev_busy) begin
        if (exp_q.size() == 0) chk("unexpected_grant", 32'(grant), 32'h0);
        else begin
          e = exp_q.pop_front();
          oh = N'(1) << e;
          chk("grant", 32'(grant), 32'(oh));
          chk("grant_id", 32'(grant_id), 32'(e));
        end
        held = grant;
      end else if (busy) begin
        if (grant !== held) chk("grant_hold", 32'(grant), 32'(held));
      end else if (grant !== '0) chk("idle_grant", 32'(grant), 32'h0);
      prev_busy = busy;
    end
  end

  initial begin
    logic [N-1:0] r;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    step(8'h01, 1'b0, 1'b0, 3'd0, 4'd0);
    @(posedge clk);
    #1;
    chk("first_grant", 32'(grant), 32'h01);
    chk("first_busy", 32'(busy), 32'h1);
    step(8'h01, 1'b1, 1'b0, 3'd0, 4'd0);
    @(posedge clk);
    #1;
    chk("done_drop", 32'(grant), 32'h0);
    run(8'h00, 2);
    do_reset();
    run(8'hFF, 34);
    run(8'h00, 2);
    do_reset();
    step(8'h00, 1'b0, 1'b1, 3'd2, 4'd3);
    step(8'h00, 1'b0, 1'b1, 3'd5, 4'd1);
    run(8'h24, 18);
    run(8'h00, 2);
    do_reset();
    step(8'h08, 1'b0, 1'b0, 3'd0, 4'd0);
    repeat (3) step(8'h00, 1'b0, 1'b0, 3'd0, 4'd0);
    repeat (2) step(8'h0C, 1'b0, 1'b0, 3'd0, 4'd0);
    run(8'h0C, 8);
    run(8'h00, 2);
    do_reset();
    step(8'h00, 1'b0, 1'b1, 3'd4, 4'd3);
    run(8'h10, 3);
    do_reset();
    run(8'h10, 6);
    run(8'h00, 2);
    do_reset();
    step(8'h00, 1'b0, 1'b1, 3'd0, 4'd4);
    run(8'h03, 12);
    run(8'h00, 2);
    do_reset();
    step(8'h00, 1'b0, 1'b1, 3'd3, 4'd0);
    run(8'h08, 6);
    r = 8'($urandom);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom);
      step(r, m_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0),
           $urandom_range(7) == 0, 3'($urandom), 4'($urandom_range(3)));
    end
    run(8'h00, 4);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
